// File: rtl/layer_priority_sort.sv
// ============================================================================
// Module      : layer_priority_sort
// Description : Two-stage per-pixel layer sorter choosing the first and second
//               visible layers among OBJ, BG0-BG3 and the backdrop.
//               Optional feature macro: LAYER_SORT_SECOND_EN (second-layer search).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_priority_sort #(
    parameter int PIPE_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0][15:0] bg_color,
    input  logic [3:0][1:0]  bg_prio,
    input  logic [15:0]      obj_color,
    input  logic [1:0]       obj_prio,
    input  logic             obj_semi,
    input  logic [15:0]      bd_color,
    input  logic [4:0]       layer_en,
    input  logic [4:0]       win_effects,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [19:0]      layer0,
    output logic [19:0]      layer1,
    output logic [15:0]      color0,
    output logic [15:0]      color1,
    output logic [4:0]       effects
);

    localparam int         NCAND   = 5;       // OBJ, BG0..BG3
    localparam logic [2:0] C_BD_ID   = 3'd5;
    localparam logic [5:0] C_BD_KEY  = 6'h3F;
    localparam logic [19:0] C_BD_DESC = 20'hD0000;

    generate
        if (PIPE_STAGES != 2) begin : g_bad_depth
            $error("layer_priority_sort: only PIPE_STAGES = 2 is supported");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Candidate extraction; index 0 = OBJ, index n+1 = BGn
    // ------------------------------------------------------------------
    logic [NCAND-1:0]        w_mask;
    logic [NCAND-1:0][5:0]   w_key;
    logic [NCAND-1:0][14:0]  w_col;

    assign w_mask[0] = layer_en[4] & ~obj_color[15];
    assign w_key[0]  = {1'b0, obj_prio, 3'd0};
    assign w_col[0]  = obj_color[14:0];

    generate
        for (genvar n = 0; n < 4; n++) begin : g_bg
            assign w_mask[n+1] = layer_en[n] & ~bg_color[n][15];
            assign w_key[n+1]  = {1'b0, bg_prio[n], 3'(n + 1)};
            assign w_col[n+1]  = bg_color[n][14:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s1_adv;
    logic w_s2_adv;

    assign w_s2_adv = ~r_s2_valid | out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv;

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [NCAND-1:0]        r_s1_mask;
    logic [NCAND-1:0][5:0]   r_s1_key;
    logic [NCAND-1:0][14:0]  r_s1_col;
    logic [14:0]             r_s1_bd;
    logic                    r_s1_semi;
    logic [4:0]              r_s1_fx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_mask  <= '0;
            r_s1_key   <= '0;
            r_s1_col   <= '0;
            r_s1_bd    <= '0;
            r_s1_semi  <= 1'b0;
            r_s1_fx    <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_mask <= w_mask;
                r_s1_key  <= w_key;
                r_s1_col  <= w_col;
                r_s1_bd   <= bd_color[14:0];
                r_s1_semi <= obj_semi;
                r_s1_fx   <= win_effects;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 selection: backdrop seeds both slots so it fills any gap
    // ------------------------------------------------------------------
    logic [2:0] w_first_id;
    logic [5:0] w_first_key;

`ifdef LAYER_SORT_SECOND_EN
    logic [2:0] w_second_id;
    logic [5:0] w_second_key;

    always_comb begin
        w_first_id   = C_BD_ID;
        w_first_key  = C_BD_KEY;
        w_second_id  = C_BD_ID;
        w_second_key = C_BD_KEY;
        for (int c = 0; c < NCAND; c++) begin
            if (r_s1_mask[c]) begin
                if (r_s1_key[c] < w_first_key) begin
                    w_second_id  = w_first_id;
                    w_second_key = w_first_key;
                    w_first_id   = 3'(c);
                    w_first_key  = r_s1_key[c];
                end else if (r_s1_key[c] < w_second_key) begin
                    w_second_id  = 3'(c);
                    w_second_key = r_s1_key[c];
                end
            end
        end
    end
`else
    always_comb begin
        w_first_id  = C_BD_ID;
        w_first_key = C_BD_KEY;
        for (int c = 0; c < NCAND; c++) begin
            if (r_s1_mask[c] && (r_s1_key[c] < w_first_key)) begin
                w_first_id  = 3'(c);
                w_first_key = r_s1_key[c];
            end
        end
    end
`endif

    function automatic logic [19:0] f_desc(
        input logic [2:0]            id,
        input logic [NCAND-1:0][5:0] key,
        input logic                  semi
    );
        logic [19:0] d;
        d = '0;
        if (id == C_BD_ID) begin
            d = C_BD_DESC;
        end else if (id == 3'd0) begin
            d[19:18] = key[0][4:3];
            d[17]    = 1'b1;
            d[13]    = semi;
        end else begin
            d[19:18] = key[id][4:3];
            d[9:8]   = 2'(id - 3'd1);
        end
        return d;
    endfunction

    function automatic logic [15:0] f_col(
        input logic [2:0]             id,
        input logic [NCAND-1:0][14:0] col,
        input logic [14:0]            bd
    );
        return (id == C_BD_ID) ? {1'b0, bd} : {1'b0, col[id]};
    endfunction

    // ------------------------------------------------------------------
    // Stage 2 registers (output bundle)
    // ------------------------------------------------------------------
    logic [19:0] r_layer0;
    logic [19:0] r_layer1;
    logic [15:0] r_color0;
    logic [15:0] r_color1;
    logic [4:0]  r_effects;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_layer0   <= '0;
            r_layer1   <= '0;
            r_color0   <= '0;
            r_color1   <= '0;
            r_effects  <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_layer0  <= f_desc(w_first_id, r_s1_key, r_s1_semi);
                r_color0  <= f_col(w_first_id, r_s1_col, r_s1_bd);
                r_effects <= r_s1_fx;
`ifdef LAYER_SORT_SECOND_EN
                r_layer1  <= f_desc(w_second_id, r_s1_key, r_s1_semi);
                r_color1  <= f_col(w_second_id, r_s1_col, r_s1_bd);
`else
                r_layer1  <= C_BD_DESC;
                r_color1  <= {1'b0, r_s1_bd};
`endif
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign layer0    = r_layer0;
    assign layer1    = r_layer1;
    assign color0    = r_color0;
    assign color1    = r_color1;
    assign effects   = r_effects;

    // Backdrop transparency bit carries no meaning here
    logic w_unused;
    assign w_unused = bd_color[15];

endmodule

`default_nettype wire

// File: tb/tb_layer_priority_sort.sv
// ============================================================================
// Module      : tb_layer_priority_sort
// Description : Self-checking bench for layer_priority_sort with a sorted-list
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_layer_priority_sort;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0][15:0] bg_color;
    logic [3:0][1:0]  bg_prio;
    logic [15:0]      obj_color;
    logic [1:0]       obj_prio;
    logic             obj_semi;
    logic [15:0]      bd_color;
    logic [4:0]       layer_en;
    logic [4:0]       win_effects;
    logic             out_valid;
    logic             out_ready;
    logic [19:0]      layer0;
    logic [19:0]      layer1;
    logic [15:0]      color0;
    logic [15:0]      color1;
    logic [4:0]       effects;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    layer_priority_sort #(.PIPE_STAGES(2)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .bg_color(bg_color), .bg_prio(bg_prio),
        .obj_color(obj_color), .obj_prio(obj_prio), .obj_semi(obj_semi),
        .bd_color(bd_color), .layer_en(layer_en), .win_effects(win_effects),
        .out_valid(out_valid), .out_ready(out_ready),
        .layer0(layer0), .layer1(layer1),
        .color0(color0), .color1(color1), .effects(effects)
    );

    typedef struct packed {
        logic [3:0][15:0] bgc;
        logic [3:0][1:0]  bgp;
        logic [15:0]      objc;
        logic [1:0]       objp;
        logic             semi;
        logic [15:0]      bd;
        logic [4:0]       en;
        logic [4:0]       fx;
    } pix_t;

    typedef struct packed {
        logic [19:0] l0;
        logic [19:0] l1;
        logic [15:0] c0;
        logic [15:0] c1;
        logic [4:0]  fx;
    } exp_t;

    // ---------------- reference model ----------------
    // Each visible layer gets order value prio*5 + class (OBJ=0, BGn=n+1);
    // backdrop is 100. Sorting the list gives first/second directly.
    function automatic int id_of(input int v);
        return (v == 100) ? 5 : (v % 5);
    endfunction

    function automatic logic [19:0] ref_desc(input pix_t p, input int id);
        logic [19:0] d;
        if (id == 5)      d = 20'hD0000;
        else if (id == 0) d = {p.objp, 1'b1, 1'b0, 2'b00, p.semi, 13'd0};
        else              d = {p.bgp[id-1], 4'b0, 4'b0, 2'(id - 1), 8'd0};
        return d;
    endfunction

    function automatic logic [15:0] ref_col(input pix_t p, input int id);
        logic [15:0] c;
        if (id == 5)      c = p.bd;
        else if (id == 0) c = p.objc;
        else              c = p.bgc[id-1];
        return c & 16'h7FFF;
    endfunction

    function automatic exp_t model(input pix_t p);
        int   q[$];
        int   a;
        int   b;
        exp_t e;
        if (p.en[4] && !p.objc[15]) q.push_back(int'(p.objp) * 5);
        for (int n = 0; n < 4; n++)
            if (p.en[n] && !p.bgc[n][15]) q.push_back(int'(p.bgp[n]) * 5 + n + 1);
        q.push_back(100);
        q.sort();
        a = id_of(q[0]);
        b = (q.size() > 1) ? id_of(q[1]) : a;
        e.l0 = ref_desc(p, a);
        e.c0 = ref_col(p, a);
`ifdef LAYER_SORT_SECOND_EN
        e.l1 = ref_desc(p, b);
        e.c1 = ref_col(p, b);
`else
        e.l1 = 20'hD0000;
        e.c1 = p.bd & 16'h7FFF;
        if (b < 0) e.l1 = 20'h0;
`endif
        e.fx = p.fx;
        return e;
    endfunction

    function automatic pix_t rand_pix();
        pix_t p;
        for (int n = 0; n < 4; n++) begin
            p.bgc[n] = 16'($urandom);
            p.bgp[n] = 2'($urandom);
        end
        p.objc = 16'($urandom);
        p.objp = 2'($urandom);
        p.semi = 1'($urandom);
        p.bd   = 16'($urandom);
        p.en   = 5'($urandom);
        p.fx   = 5'($urandom);
        return p;
    endfunction

    function automatic pix_t blank_pix();
        pix_t p;
        p      = '0;
        p.bgc  = {4{16'h8000}};
        p.objc = 16'h8000;
        return p;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic drive(input pix_t p);
        bg_color    = p.bgc;
        bg_prio     = p.bgp;
        obj_color   = p.objc;
        obj_prio    = p.objp;
        obj_semi    = p.semi;
        bd_color    = p.bd;
        layer_en    = p.en;
        win_effects = p.fx;
    endtask

    function automatic exp_t observed();
        return {layer0, layer1, color0, color1, effects};
    endfunction

    // Sends one pixel into an empty pipeline; lat = cycles until out_valid, -1 on timeout
    task automatic run_one(input pix_t p, output exp_t got, output int lat);
        @(negedge clock);
        drive(p);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        lat = -1;
        got = '0;
        if (in_ready) begin
            @(negedge clock);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(negedge clock);
                lat++;
            end
            if (!out_valid) lat = -1;
            got = observed();
        end
        in_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(blank_pix());
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++;
        if (observed() !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", observed()); end
    endtask

    task automatic test_two_bg();
        pix_t p;
        exp_t got;
        int   lat;
        p = blank_pix();
        p.bgc[0] = 16'h001F; p.bgp[0] = 2'd2;
        p.bgc[1] = 16'h03E0; p.bgp[1] = 2'd1;
        p.en = 5'b01111;
        p.bd = 16'h0ABC;
        p.fx = 5'b10101;
        run_one(p, got, lat);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL two_bg_latency: got %0d want 2", lat); end
        total++;
        if (got.l0 !== 20'h40100 || got.c0 !== 16'h03E0) begin
            bad++; $display("FAIL two_bg_first: got %h/%h want 40100/03e0", got.l0, got.c0);
        end
`ifdef LAYER_SORT_SECOND_EN
        total++;
        if (got.l1 !== 20'h80000 || got.c1 !== 16'h001F) begin
            bad++; $display("FAIL two_bg_second: got %h/%h want 80000/001f", got.l1, got.c1);
        end
`else
        total++;
        if (got.l1 !== 20'hD0000 || got.c1 !== 16'h0ABC) begin
            bad++; $display("FAIL two_bg_second_bd: got %h/%h want d0000/0abc", got.l1, got.c1);
        end
`endif
        total++;
        if (got.fx !== 5'b10101) begin bad++; $display("FAIL two_bg_effects: got %b want 10101", got.fx); end
    endtask

    task automatic test_obj_semi();
        pix_t p;
        exp_t got;
        int   lat;
        p = blank_pix();
        p.objc = 16'h7C00; p.objp = 2'd1; p.semi = 1'b1;
        p.bgc[2] = 16'h1111; p.bgp[2] = 2'd1;
        p.en = 5'b11111;
        p.bd = 16'h0042;
        run_one(p, got, lat);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL obj_latency: got %0d want 2", lat); end
        total++;
        if (got.l0 !== 20'h62000 || got.c0 !== 16'h7C00) begin
            bad++; $display("FAIL obj_first: got %h/%h want 62000/7c00", got.l0, got.c0);
        end
`ifdef LAYER_SORT_SECOND_EN
        total++;
        if (got.l1 !== 20'h40200 || got.c1 !== 16'h1111) begin
            bad++; $display("FAIL obj_second: got %h/%h want 40200/1111", got.l1, got.c1);
        end
`else
        total++;
        if (got.l1 !== 20'hD0000 || got.c1 !== 16'h0042) begin
            bad++; $display("FAIL obj_second_bd: got %h/%h want d0000/0042", got.l1, got.c1);
        end
`endif
    endtask

    task automatic test_backdrop_only();
        pix_t p;
        exp_t got;
        int   lat;
        p = blank_pix();
        p.en = 5'b11111;
        p.bd = 16'h1234;
        run_one(p, got, lat);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL bd_latency: got %0d want 2", lat); end
        total++;
        if (got.l0 !== 20'hD0000 || got.l1 !== 20'hD0000) begin
            bad++; $display("FAIL bd_layers: got %h/%h want d0000/d0000", got.l0, got.l1);
        end
        total++;
        if (got.c0 !== 16'h1234 || got.c1 !== 16'h1234) begin
            bad++; $display("FAIL bd_colors: got %h/%h want 1234/1234", got.c0, got.c1);
        end
    endtask

    task automatic test_backpressure();
        pix_t px[8];
        exp_t q[$];
        exp_t got;
        int   sent = 0;
        int   rcvd = 0;
        bit   saw_low = 1'b0;
        for (int i = 0; i < 8; i++) px[i] = rand_pix();
        for (int k = 0; k < 60 && rcvd < 8; k++) begin
            @(negedge clock);
            got = observed();
            out_ready = !(k >= 3 && k <= 6);
            if (sent < 8) begin drive(px[sent]); in_valid = 1'b1; end
            else in_valid = 1'b0;
            #1;
            if (!in_ready) saw_low = 1'b1;
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL bp_extra_output: got %h want none", got);
                end else begin
                    if (got !== q[0]) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", rcvd, got, q[0]); end
                    void'(q.pop_front());
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin q.push_back(model(px[sent])); sent++; end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (rcvd !== 8) begin bad++; $display("FAIL bp_count: got %0d want 8", rcvd); end
        total++;
        if (saw_low !== 1'b1) begin bad++; $display("FAIL bp_in_ready_drop: got %b want 1", saw_low); end
        repeat (3) @(negedge clock);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_duplicate: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        pix_t a;
        pix_t b;
        pix_t c;
        exp_t got;
        int   lat;
        a = rand_pix(); b = rand_pix(); c = rand_pix();
        @(negedge clock); drive(a); in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clock); drive(b);
        @(negedge clock); in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid: got %b want 1", out_valid); end
        #2 reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid: got %b want 0", out_valid); end
        total++;
        if (in_ready !== 1'b1 || layer0 !== 20'h0) begin
            bad++; $display("FAIL rst_async_state: got %b/%h want 1/00000", in_ready, layer0);
        end
        @(negedge clock);
        reset = 1'b0;
        run_one(c, got, lat);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL rst_latency: got %0d want 2", lat); end
        total++;
        if (got !== model(c)) begin bad++; $display("FAIL rst_data: got %h want %h", got, model(c)); end
        @(negedge clock);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_stale: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t got;
        pix_t p;
        int   rcvd = 0;
        int   k = 0;
        while (k < 600 && (k < 300 || q.size() != 0)) begin
            @(negedge clock);
            got = observed();
            if (k < 300) begin
                p = rand_pix();
                drive(p);
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL b2b_extra_output: got %h want none", got);
                end else begin
                    if (got !== q[0]) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", rcvd, got, q[0]); end
                    void'(q.pop_front());
                end
                rcvd++;
            end
            if (in_valid && in_ready) q.push_back(model(p));
            k++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (q.size() !== 0) begin bad++; $display("FAIL b2b_drain: got %0d pending want 0", q.size()); end
        // Full-rate streaming: one pixel in and one out every cycle
        rcvd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            p = rand_pix();
            drive(p);
            in_valid = (i < 16);
            #1;
            if (i >= 2 && i < 18) begin
                total++;
                if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
                    bad++; $display("FAIL b2b_throughput[%0d]: got %b%b want 11", i, out_valid, in_ready);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_two_bg();
        test_obj_semi();
        test_backdrop_only();
        test_backpressure();
        test_reset_midstream();
        test_back_to_back();
        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
